// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch unit with redirect support and a prefetch FIFO.
// Generates sequential PCs, issues reads to a fixed-latency instruction memory,
// tracks outstanding reads in a MEM_LAT-deep pipe and buffers the returned
// instructions in a DEPTH-entry FIFO that decode drains over valid/ready.
// A redirect flushes the FIFO and all in-flight reads and restarts at a new PC.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   - a misaligned redirect target produces one error marker entry
//               {target, 0x13, err=1} and fetch halts until the next redirect.
//   undefined - redirect targets are aligned down to a word; err is tied to 0.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  restart target
//   imem_ren_o     memory read strobe
//   imem_addr_o    memory read address (current fetch PC)
//   imem_rdata_i   memory read data, valid MEM_LAT cycles after the request
//   valid_o        FIFO head valid
//   ready_i        consumer accepts head
//   pc_o           head PC
//   insn_o         head instruction
//   err_o          head entry is a misaligned-target marker
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH    = 4,
    parameter int                MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_ren_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic              err_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int LAST = MEM_LAT - 1;
    // Wide enough for count + inflight without overflow (inflight <= 4).
    localparam int SW   = CW + 3;

    logic [AWIDTH-1:0] fetch_pc_reg;
    logic [AWIDTH-1:0] fetch_pc_next;

    logic              pipe_valid_reg [MEM_LAT];
    logic [AWIDTH-1:0] pipe_pc_reg    [MEM_LAT];

    logic [AWIDTH-1:0] fifo_pc_reg    [DEPTH];
    logic [DWIDTH-1:0] fifo_insn_reg  [DEPTH];
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;

    logic [2:0]        inflight;
    logic [SW-1:0]     credit;
    logic              pop;
    logic              push;
    logic              issue;
    logic [AWIDTH-1:0] target_pc;
    logic [AWIDTH-1:0] push_pc;
    logic [DWIDTH-1:0] push_insn;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              fifo_err_reg [DEPTH];
    logic              halt_reg;
    logic              marker_reg;
    logic              misaligned;
    logic              push_err;
`endif

    // ------------------------------------------------------------------
    // Credit accounting: every issued read is guaranteed a FIFO slot, so
    // the FIFO can never overflow regardless of ready_i behaviour.
    // ------------------------------------------------------------------
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 3'(pipe_valid_reg[i]);
        end
    end

    assign valid_o = (count_reg != '0);
    assign pop     = valid_o && ready_i;
    assign credit  = SW'(count_reg) + SW'(inflight) - SW'(pop);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = |redirect_pc_i[1:0];
    assign target_pc  = redirect_pc_i;
    // The marker is pushed in the cycle after the flushing redirect, when the
    // pipe is guaranteed empty, so it never collides with a memory response.
    assign push       = marker_reg | pipe_valid_reg[LAST];
    assign push_pc    = marker_reg ? fetch_pc_reg : pipe_pc_reg[LAST];
    assign push_insn  = marker_reg ? DWIDTH'(32'h0000_0013) : imem_rdata_i;
    assign push_err   = marker_reg;
    assign issue      = rst && !redirect_i && !halt_reg && (credit < SW'(DEPTH));
`else
    assign target_pc  = redirect_pc_i & ~AWIDTH'(3);
    assign push       = pipe_valid_reg[LAST];
    assign push_pc    = pipe_pc_reg[LAST];
    assign push_insn  = imem_rdata_i;
    assign issue      = rst && !redirect_i && (credit < SW'(DEPTH));
`endif

    assign imem_ren_o  = issue;
    assign imem_addr_o = fetch_pc_reg;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        count_next    = count_reg;
        if (issue) begin
            fetch_pc_next = fetch_pc_reg + AWIDTH'(4);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state: fetch PC, FIFO occupancy and pointers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_reg <= BASEADDR;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_reg     <= 1'b0;
            marker_reg   <= 1'b0;
`endif
        end else if (redirect_i) begin
            fetch_pc_reg <= target_pc;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_reg     <= misaligned;
            marker_reg   <= misaligned;
`endif
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            marker_reg   <= 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // In-flight pipe: stage 0 captures the issued request, the last stage
    // lines up with the memory data and triggers the FIFO push.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            logic              in_valid;
            logic [AWIDTH-1:0] in_pc;

            if (gi == 0) begin : g_first
                assign in_valid = issue;
                assign in_pc    = fetch_pc_reg;
            end else begin : g_next
                assign in_valid = pipe_valid_reg[gi-1];
                assign in_pc    = pipe_pc_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rst || redirect_i) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_pc_reg[gi]    <= '0;
                end else begin
                    pipe_valid_reg[gi] <= in_valid;
                    pipe_pc_reg[gi]    <= in_pc;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO storage. Kept in flops so the head is readable combinationally
    // and can be cleared to zero on reset.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (!rst) begin
                    fifo_pc_reg[gi]   <= '0;
                    fifo_insn_reg[gi] <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                    fifo_err_reg[gi]  <= 1'b0;
`endif
                end else if (!redirect_i && push && (wr_ptr_reg == PW'(gi))) begin
                    fifo_pc_reg[gi]   <= push_pc;
                    fifo_insn_reg[gi] <= push_insn;
`ifdef FETCH_ALIGN_CHECK_EN
                    fifo_err_reg[gi]  <= push_err;
`endif
                end
            end
        end
    endgenerate

    assign pc_o   = fifo_pc_reg[rd_ptr_reg];
    assign insn_o = fifo_insn_reg[rd_ptr_reg];
`ifdef FETCH_ALIGN_CHECK_EN
    assign err_o  = fifo_err_reg[rd_ptr_reg];
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. Instance u_dut uses MEM_LAT=1, DEPTH=4 and is
// driven cycle by cycle from a table of {inputs, expected outputs}. Instance
// u_dut3 uses MEM_LAT=3, DEPTH=4 and covers first-valid latency, back-pressure
// and random ready toggling. The memory model returns ~addr.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam logic [31:0] B = 32'h0100_0000;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        err;

    logic        rst3;
    logic        redirect3;
    logic [31:0] redirect_pc3;
    logic        ren3;
    logic [31:0] addr3;
    logic [31:0] rdata3;
    logic        valid3;
    logic        ready3;
    logic [31:0] pc3;
    logic [31:0] insn3;
    logic        err3;
    logic [31:0] mem3 [3];

    int vec_cnt     = 0;
    int miscompares = 0;

    fetch_queue #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(B), .DEPTH(4), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_ren_o(ren), .imem_addr_o(addr), .imem_rdata_i(rdata),
        .valid_o(valid), .ready_i(ready), .pc_o(pc), .insn_o(insn), .err_o(err)
    );

    fetch_queue #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(B), .DEPTH(4), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3), .redirect_i(redirect3), .redirect_pc_i(redirect_pc3),
        .imem_ren_o(ren3), .imem_addr_o(addr3), .imem_rdata_i(rdata3),
        .valid_o(valid3), .ready_i(ready3), .pc_o(pc3), .insn_o(insn3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency memory models: data = ~address.
    always @(posedge clk) rdata <= ~addr;
    always @(posedge clk) begin
        mem3[0] <= ~addr3;
        mem3[1] <= mem3[0];
        mem3[2] <= mem3[1];
    end
    assign rdata3 = mem3[2];

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        eren;
        logic [31:0] eaddr;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, input logic eren,
                                input logic [31:0] eaddr, input logic eerr);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eren = eren; v.eaddr = eaddr; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp3;
        int          pops;

        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        rst3 = 1'b0; redirect3 = 1'b0; redirect_pc3 = '0; ready3 = 1'b0;

        // ---------------- vector table for u_dut (MEM_LAT=1) ----------------
        //   rdy redir rpc              ev  epc              ren addr            err
        add(1, 0, 0,                    0, 0,               1, B,              0); // c0
        add(1, 0, 0,                    0, 0,               1, B + 32'h04,     0);
        add(1, 0, 0,                    1, B,               1, B + 32'h08,     0); // first valid
        add(1, 0, 0,                    1, B + 32'h04,      1, B + 32'h0C,     0);
        add(0, 0, 0,                    1, B + 32'h08,      1, B + 32'h10,     0); // stall begins
        add(0, 0, 0,                    1, B + 32'h08,      1, B + 32'h14,     0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0,                1, B + 32'h08,      0, B + 32'h18,     0); // credits exhausted
        add(1, 0, 0,                    1, B + 32'h08,      1, B + 32'h18,     0); // release
        add(1, 0, 0,                    1, B + 32'h0C,      1, B + 32'h1C,     0);
        add(1, 0, 0,                    1, B + 32'h10,      1, B + 32'h20,     0);
        add(1, 0, 0,                    1, B + 32'h14,      1, B + 32'h24,     0);
        add(1, 0, 0,                    1, B + 32'h18,      1, B + 32'h28,     0);
        add(1, 0, 0,                    1, B + 32'h1C,      1, B + 32'h2C,     0);
        add(0, 1, B + 32'h100,          1, B + 32'h20,      0, B + 32'h30,     0); // redirect, full credit
        add(1, 0, 0,                    0, 0,               1, B + 32'h100,    0);
        add(1, 0, 0,                    0, 0,               1, B + 32'h104,    0);
        add(1, 0, 0,                    1, B + 32'h100,     1, B + 32'h108,    0);
        add(1, 0, 0,                    1, B + 32'h104,     1, B + 32'h10C,    0);
        add(1, 1, B + 32'h102,          1, B + 32'h108,     0, B + 32'h110,    0); // misaligned target
`ifdef FETCH_ALIGN_CHECK_EN
        add(1, 0, 0,                    0, 0,               0, B + 32'h102,    0);
        add(1, 0, 0,                    1, B + 32'h102,     0, B + 32'h102,    1); // marker
        add(1, 0, 0,                    0, 0,               0, B + 32'h102,    0); // halted
        add(1, 1, 32'hFFFF_FFF8,        0, 0,               0, B + 32'h102,    0);
`else
        add(1, 0, 0,                    0, 0,               1, B + 32'h100,    0);
        add(1, 0, 0,                    0, 0,               1, B + 32'h104,    0);
        add(1, 0, 0,                    1, B + 32'h100,     1, B + 32'h108,    0);
        add(1, 1, 32'hFFFF_FFF8,        1, B + 32'h104,     0, B + 32'h10C,    0);
`endif
        add(1, 0, 0,                    0, 0,               1, 32'hFFFF_FFF8,  0);
        add(1, 0, 0,                    0, 0,               1, 32'hFFFF_FFFC,  0);
        add(1, 0, 0,                    1, 32'hFFFF_FFF8,   1, 32'h0000_0000,  0); // address wrap
        add(1, 0, 0,                    1, 32'hFFFF_FFFC,   1, 32'h0000_0004,  0);
        add(1, 0, 0,                    1, 32'h0000_0000,   1, 32'h0000_0008,  0);
        add(1, 1, 32'h0200_0000,        1, 32'h0000_0004,   0, 32'h0000_000C,  0); // back-to-back
        add(1, 1, 32'h0300_0000,        0, 0,               0, 32'h0200_0000,  0);
        add(1, 0, 0,                    0, 0,               1, 32'h0300_0000,  0);
        add(1, 0, 0,                    0, 0,               1, 32'h0300_0004,  0);
        add(1, 0, 0,                    1, 32'h0300_0000,   1, 32'h0300_0008,  0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.ren",   32'(ren),   32'd0);
        chk("rst.addr",  addr,       B);
        chk("rst.pc",    pc,         32'd0);
        chk("rst.insn",  insn,       32'd0);
        chk("rst.err",   32'(err),   32'd0);
        $display("reset: valid=%0d ren=%0d addr=%08h pc=%08h", valid, ren, addr, pc);
        rst = 1'b1;

        // ---------------- table-driven phase ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            ready       = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d.valid", i), 32'(valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d.ren", i),   32'(ren),   32'(vecs[i].eren));
            chk($sformatf("v%0d.addr", i),  addr,       vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d.pc", i),   pc,        vecs[i].epc);
                chk($sformatf("v%0d.insn", i), insn,
                    vecs[i].eerr ? 32'h0000_0013 : ~vecs[i].epc);
                chk($sformatf("v%0d.err", i),  32'(err),  32'(vecs[i].eerr));
            end
            $display("vec %0d: rdy=%0d redir=%0d valid=%0d pc=%08h ren=%0d addr=%08h",
                     i, ready, redirect, valid, pc, ren, addr);
            @(negedge clk);
        end
        redirect = 1'b0;

        // ---------------- reset in mid-stream ----------------
        rst   = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst.valid", 32'(valid), 32'd0);
        chk("midrst.ren",   32'(ren),   32'd0);
        chk("midrst.addr",  addr,       B);
        chk("midrst.pc",    pc,         32'd0);
        chk("midrst.insn",  insn,       32'd0);
        rst = 1'b1;
        #1;
        chk("midrst.c0.ren",  32'(ren), 32'd1);
        chk("midrst.c0.addr", addr,     B);
        @(negedge clk);
        #1;
        chk("midrst.c1.valid", 32'(valid), 32'd0);
        chk("midrst.c1.addr",  addr,       B + 32'h04);
        @(negedge clk);
        #1;
        chk("midrst.c2.valid", 32'(valid), 32'd1);
        chk("midrst.c2.pc",    pc,         B);
        chk("midrst.c2.insn",  insn,       ~B);
        $display("midrst: valid=%0d pc=%08h", valid, pc);
        @(negedge clk);

        // ---------------- MEM_LAT=3 instance ----------------
        rst3   = 1'b1;
        ready3 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (c == 0) begin
                chk("lat3.c0.ren",  32'(ren3), 32'd1);
                chk("lat3.c0.addr", addr3,     B);
            end
            chk($sformatf("lat3.c%0d.valid", c), 32'(valid3), (c >= 4) ? 32'd1 : 32'd0);
            if (c >= 4) begin
                chk($sformatf("lat3.c%0d.pc", c),   pc3,   B + 32'(4 * (c - 4)));
                chk($sformatf("lat3.c%0d.insn", c), insn3, ~(B + 32'(4 * (c - 4))));
            end
            $display("lat3 cycle %0d: valid=%0d pc=%08h", c, valid3, pc3);
            @(negedge clk);
        end
        exp3 = B + 32'h14;

        // Long stall: credits run out and the head holds.
        ready3 = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("lat3.stall.ren",   32'(ren3),   32'd0);
        chk("lat3.stall.valid", 32'(valid3), 32'd1);
        chk("lat3.stall.pc",    pc3,         exp3);
        chk("lat3.stall.err",   32'(err3),   32'd0);
        @(negedge clk);

        // Random back-pressure: every accepted entry must arrive in order.
        pops = 0;
        for (int c = 0; c < 60; c++) begin
            ready3 = 1'($urandom_range(0, 1));
            #1;
            if (valid3 && ready3) begin
                chk($sformatf("lat3.rnd%0d.pc", c),   pc3,   exp3);
                chk($sformatf("lat3.rnd%0d.insn", c), insn3, ~exp3);
                $display("lat3 pop: pc=%08h", pc3);
                exp3 = exp3 + 32'h4;
                pops++;
            end
            @(negedge clk);
        end

        // Free-running drain: after the pipe refills, one entry per cycle.
        ready3 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c >= 4) begin
                chk($sformatf("lat3.run%0d.valid", c), 32'(valid3), 32'd1);
            end
            if (valid3) begin
                chk($sformatf("lat3.run%0d.pc", c), pc3, exp3);
                exp3 = exp3 + 32'h4;
                pops++;
            end
            @(negedge clk);
        end
        $display("lat3 total pops after stall: %0d", pops);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
